// File: rtl/memblk_pkg.sv
// memblk_pkg: default configuration, shared record types and helpers for the
// translated multi-port line memory.
package memblk_pkg;

  localparam int NPORT_DEF = 4;
  localparam int DW_DEF    = 64;
  localparam int VAW_DEF   = 37;
  localparam int LAW_DEF   = 10;
  localparam int POFF_DEF  = 6;
  localparam int NTLB_DEF  = 8;

  localparam int VPNW_DEF  = VAW_DEF - POFF_DEF;
  localparam int PPNW_DEF  = LAW_DEF - POFF_DEF;

  // Record layouts below are sized for the default configuration.
  typedef struct packed {
    logic                v;
    logic [VPNW_DEF-1:0] vpn;
    logic [PPNW_DEF-1:0] ppn;
  } tlb_entry_t;

  typedef struct packed {
    logic               we;
    logic [VAW_DEF-1:0] vaddr;
    logic [DW_DEF-1:0]  wdata;
  } req_t;

  typedef struct packed {
    logic              fault;
    logic [DW_DEF-1:0] rdata;
  } resp_t;

  // Ceiling log2, never below 1 so a one-entry table still gets an index port.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/memblk_tlb.sv
// memblk_tlb: shared fully associative translation table. Entries are
// registered; every port gets its own combinational lookup.
module memblk_tlb
  import memblk_pkg::*;
#(
  parameter int NPORT = NPORT_DEF,
  parameter int NTLB  = NTLB_DEF,
  parameter int VPNW  = VPNW_DEF,
  parameter int PPNW  = PPNW_DEF,
  localparam int IW   = clog2(NTLB)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fill_vld,
  input  logic [IW-1:0]         fill_idx,
  input  logic [VPNW-1:0]       fill_vpn,
  input  logic [PPNW-1:0]       fill_ppn,
  input  logic                  fill_v,
  input  logic                  flush,
  input  logic [NPORT*VPNW-1:0] lk_vpn,
  output logic [NPORT-1:0]      lk_hit,
  output logic [NPORT*PPNW-1:0] lk_ppn
);

  logic [NTLB-1:0]           ent_v;
  logic [NTLB-1:0][VPNW-1:0] ent_vpn;
  logic [NTLB-1:0][PPNW-1:0] ent_ppn;

  for (genvar gi = 0; gi < NTLB; gi++) begin : g_entry
    logic            v_reg;
    logic [VPNW-1:0] vpn_reg;
    logic [PPNW-1:0] ppn_reg;
    logic            sel;

    assign sel = fill_vld && (fill_idx == IW'(gi));

    // Entry update: a flush beats a same-cycle fill; otherwise a fill rewrites the selected entry.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_reg   <= 1'b0;
        vpn_reg <= '0;
        ppn_reg <= '0;
      end else if (flush) begin
        v_reg   <= 1'b0;
      end else if (sel) begin
        v_reg   <= fill_v;
        vpn_reg <= fill_vpn;
        ppn_reg <= fill_ppn;
      end
    end

    assign ent_v[gi]   = v_reg;
    assign ent_vpn[gi] = vpn_reg;
    assign ent_ppn[gi] = ppn_reg;
  end

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_lookup
    logic [VPNW-1:0] vpn;
    logic            hit;
    logic [PPNW-1:0] ppn;

    assign vpn = lk_vpn[gi*VPNW +: VPNW];

    // Priority search: scanning downwards leaves the lowest matching index as the winner.
    always_comb begin
      hit = 1'b0;
      ppn = '0;
      for (int i = NTLB - 1; i >= 0; i--) begin
        if (ent_v[i] && (ent_vpn[i] == vpn)) begin
          hit = 1'b1;
          ppn = ent_ppn[i];
        end
      end
    end

    assign lk_hit[gi]              = hit;
    assign lk_ppn[gi*PPNW +: PPNW] = ppn;
  end

endmodule

// File: rtl/memblk_xlat.sv
// memblk_xlat: multi-port line memory behind a shared TLB. Each port runs an
// independent T (translate) -> M (array access) -> response pipeline that
// freezes as a whole while its response is waiting to be accepted.
module memblk_xlat
  import memblk_pkg::*;
#(
  parameter int NPORT = NPORT_DEF,
  parameter int DW    = DW_DEF,
  parameter int VAW   = VAW_DEF,
  parameter int LAW   = LAW_DEF,
  parameter int POFF  = POFF_DEF,
  parameter int NTLB  = NTLB_DEF,
  localparam int IW   = clog2(NTLB),
  localparam int VPNW = VAW - POFF,
  localparam int PPNW = LAW - POFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NPORT-1:0]     req_vld,
  output logic [NPORT-1:0]     req_rdy,
  input  logic [NPORT-1:0]     req_we,
  input  logic [NPORT*VAW-1:0] req_vaddr,
  input  logic [NPORT*DW-1:0]  req_wdata,
  output logic [NPORT-1:0]     resp_vld,
  input  logic [NPORT-1:0]     resp_rdy,
  output logic [NPORT*DW-1:0]  resp_rdata,
  output logic [NPORT-1:0]     resp_fault,
  input  logic                 fill_vld,
  input  logic [IW-1:0]        fill_idx,
  input  logic [VPNW-1:0]      fill_vpn,
  input  logic [PPNW-1:0]      fill_ppn,
  input  logic                 fill_v,
  input  logic                 flush
);

  logic [DW-1:0] mem [0:(1<<LAW)-1];

  logic [NPORT*VPNW-1:0]    lk_vpn;
  logic [NPORT-1:0]         lk_hit;
  logic [NPORT*PPNW-1:0]    lk_ppn;

  logic [NPORT-1:0]           wr_en;
  logic [NPORT-1:0][LAW-1:0]  wr_addr;
  logic [NPORT-1:0][DW-1:0]   wr_data;

  memblk_tlb #(
    .NPORT (NPORT),
    .NTLB  (NTLB),
    .VPNW  (VPNW),
    .PPNW  (PPNW)
  ) u_tlb (
    .clk      (clk),
    .rst      (rst),
    .fill_vld (fill_vld),
    .fill_idx (fill_idx),
    .fill_vpn (fill_vpn),
    .fill_ppn (fill_ppn),
    .fill_v   (fill_v),
    .flush    (flush),
    .lk_vpn   (lk_vpn),
    .lk_hit   (lk_hit),
    .lk_ppn   (lk_ppn)
  );

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
    logic            t_vld_reg;
    logic            t_we_reg;
    logic [VAW-1:0]  t_vaddr_reg;
    logic [DW-1:0]   t_wdata_reg;

    logic            m_vld_reg;
    logic            m_we_reg;
    logic            m_fault_reg;
    logic [LAW-1:0]  m_paddr_reg;
    logic [DW-1:0]   m_wdata_reg;

    logic            resp_vld_reg;
    logic            resp_fault_reg;
    logic [DW-1:0]   resp_rdata_reg;

    logic            advance;
    logic [LAW-1:0]  t_paddr;
    logic            m_rd;

    // The whole port pipeline moves only when its response slot is free or being taken.
    assign advance     = !(resp_vld_reg && !resp_rdy[gi]);
    assign req_rdy[gi] = advance;

    assign lk_vpn[gi*VPNW +: VPNW] = t_vaddr_reg[VAW-1:POFF];
    assign t_paddr = {lk_ppn[gi*PPNW +: PPNW], t_vaddr_reg[POFF-1:0]};

    assign m_rd        = m_vld_reg && !m_we_reg && !m_fault_reg;
    assign wr_en[gi]   = advance && m_vld_reg && m_we_reg && !m_fault_reg;
    assign wr_addr[gi] = m_paddr_reg;
    assign wr_data[gi] = m_wdata_reg;

    // Stage T: capture an accepted request (a bubble if nothing was offered).
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        t_vld_reg   <= 1'b0;
        t_we_reg    <= 1'b0;
        t_vaddr_reg <= '0;
        t_wdata_reg <= '0;
      end else if (advance) begin
        t_vld_reg   <= req_vld[gi];
        t_we_reg    <= req_we[gi];
        t_vaddr_reg <= req_vaddr[gi*VAW +: VAW];
        t_wdata_reg <= req_wdata[gi*DW +: DW];
      end
    end

    // Stage M: register the translation result alongside the request.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        m_vld_reg   <= 1'b0;
        m_we_reg    <= 1'b0;
        m_fault_reg <= 1'b0;
        m_paddr_reg <= '0;
        m_wdata_reg <= '0;
      end else if (advance) begin
        m_vld_reg   <= t_vld_reg;
        m_we_reg    <= t_we_reg;
        m_fault_reg <= !lk_hit[gi];
        m_paddr_reg <= t_paddr;
        m_wdata_reg <= t_wdata_reg;
      end
    end

    // Response register: reads sample the array before this edge's writes land.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        resp_vld_reg   <= 1'b0;
        resp_fault_reg <= 1'b0;
        resp_rdata_reg <= '0;
      end else if (advance) begin
        resp_vld_reg   <= m_vld_reg;
        resp_fault_reg <= m_vld_reg && m_fault_reg;
        resp_rdata_reg <= m_rd ? mem[m_paddr_reg] : '0;
      end
    end

    assign resp_vld[gi]             = resp_vld_reg;
    assign resp_fault[gi]           = resp_fault_reg;
    assign resp_rdata[gi*DW +: DW]  = resp_rdata_reg;
  end

  // Array write: ports applied in ascending order so the highest index wins a same-line collision.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORT; p++) begin
      if (wr_en[p]) begin
        mem[wr_addr[p]] <= wr_data[p];
      end
    end
  end

endmodule

// File: tb/tb_memblk_xlat.sv
`timescale 1ns/1ps
module tb_memblk_xlat;
  import memblk_pkg::*;

  localparam int NPORT = 4;
  localparam int DW    = 64;
  localparam int VAW   = 37;
  localparam int LAW   = 10;
  localparam int POFF  = 6;
  localparam int NTLB  = 8;
  localparam int IW    = clog2(NTLB);
  localparam int VPNW  = VAW - POFF;
  localparam int PPNW  = LAW - POFF;

  logic                 clk;
  logic                 rst;
  logic [NPORT-1:0]     req_vld;
  logic [NPORT-1:0]     req_rdy;
  logic [NPORT-1:0]     req_we;
  logic [NPORT*VAW-1:0] req_vaddr;
  logic [NPORT*DW-1:0]  req_wdata;
  logic [NPORT-1:0]     resp_vld;
  logic [NPORT-1:0]     resp_rdy;
  logic [NPORT*DW-1:0]  resp_rdata;
  logic [NPORT-1:0]     resp_fault;
  logic                 fill_vld;
  logic [IW-1:0]        fill_idx;
  logic [VPNW-1:0]      fill_vpn;
  logic [PPNW-1:0]      fill_ppn;
  logic                 fill_v;
  logic                 flush;

  memblk_xlat #(
    .NPORT (NPORT), .DW (DW), .VAW (VAW), .LAW (LAW), .POFF (POFF), .NTLB (NTLB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_vld    (req_vld),
    .req_rdy    (req_rdy),
    .req_we     (req_we),
    .req_vaddr  (req_vaddr),
    .req_wdata  (req_wdata),
    .resp_vld   (resp_vld),
    .resp_rdy   (resp_rdy),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .fill_vld   (fill_vld),
    .fill_idx   (fill_idx),
    .fill_vpn   (fill_vpn),
    .fill_ppn   (fill_ppn),
    .fill_v     (fill_v),
    .flush      (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  resp_t            exp_q [NPORT][$];
  resp_t            exp_cur [NPORT];
  resp_t            mon_e;
  logic [NPORT-1:0] acc;
  int               checks = 0;
  int               errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted response is popped and compared against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      for (int p = 0; p < NPORT; p++) begin
        if (resp_vld[p] && resp_rdy[p]) begin
          checks++;
          if (exp_q[p].size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected port %0d: got fault=%0b rdata=0x%0h, required no response",
                     p, resp_fault[p], resp_rdata[p*DW +: DW]);
          end else begin
            mon_e = exp_q[p].pop_front();
            if (resp_fault[p] !== mon_e.fault || resp_rdata[p*DW +: DW] !== mon_e.rdata) begin
              errors++;
              $display("FAIL resp port %0d: got fault=%0b rdata=0x%0h, required fault=%0b rdata=0x%0h",
                       p, resp_fault[p], resp_rdata[p*DW +: DW], mon_e.fault, mon_e.rdata);
            end else begin
              $display("%0t port %0d resp fault=%0b rdata=0x%0h ok",
                       $time, p, resp_fault[p], resp_rdata[p*DW +: DW]);
            end
          end
        end
      end
    end
  end

  task automatic set_req(input int p, input logic we, input logic [VAW-1:0] va,
                         input logic [DW-1:0] wd, input logic ef, input logic [DW-1:0] erd);
    req_vld[p]               = 1'b1;
    req_we[p]                = we;
    req_vaddr[p*VAW +: VAW]  = va;
    req_wdata[p*DW +: DW]    = wd;
    exp_cur[p].fault         = ef;
    exp_cur[p].rdata         = erd;
  endtask

  // One clock: record acceptances on the scoreboard, then drop accepted requests.
  task automatic cycle();
    @(negedge clk);
    acc = req_vld & req_rdy;
    for (int p = 0; p < NPORT; p++) begin
      if (acc[p]) exp_q[p].push_back(exp_cur[p]);
    end
    @(posedge clk);
    #1;
    req_vld = req_vld & ~acc;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic fill(input int idx, input int vpn, input int ppn, input logic fl);
    fill_vld = 1'b1;
    fill_idx = IW'(idx);
    fill_vpn = VPNW'(vpn);
    fill_ppn = PPNW'(ppn);
    fill_v   = 1'b1;
    flush    = fl;
    cycle();
    fill_vld = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  int lat;
  int n2;
  int n3;

  initial begin
    rst       = 1'b1;
    req_vld   = '0;
    req_we    = '0;
    req_vaddr = '0;
    req_wdata = '0;
    resp_rdy  = '1;
    fill_vld  = 1'b0;
    fill_idx  = '0;
    fill_vpn  = '0;
    fill_ppn  = '0;
    fill_v    = 1'b0;
    flush     = 1'b0;
    #2 rst = 1'b0;
    #10;
    chk("rst_resp_vld", 64'(resp_vld), 64'h0);
    chk("rst_resp_fault", 64'(resp_fault), 64'h0);
    chk("rst_resp_rdata", 64'(|resp_rdata), 64'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_req_rdy", 64'(req_rdy), 64'hF);

    // Mapping: vpn1->ppn3 (idx0), vpn2->ppn0 (idx2), duplicate vpn1->ppn5 (idx3), alias vpn7->ppn3 (idx4)
    fill(0, 1, 3, 1'b0);
    fill(2, 2, 0, 1'b0);
    fill(3, 1, 5, 1'b0);
    fill(4, 7, 3, 1'b0);
    set_req(0, 1'b1, 37'h45, 64'hA5A5, 1'b0, 64'h0);
    set_req(1, 1'b1, 37'h80, 64'hBAD0, 1'b0, 64'h0);
    cycle();
    idle(1);
    set_req(1, 1'b0, 37'h45, 64'h0, 1'b0, 64'hA5A5);
    cycle();
    set_req(2, 1'b0, 37'h45, 64'h0, 1'b0, 64'hA5A5);
    set_req(3, 1'b0, 37'h1C5, 64'h0, 1'b0, 64'hA5A5);
    cycle();
    idle(3);

    // Miss: latency 2, fault 1, rdata 0; a faulting write must leave physical line 0 alone
    set_req(0, 1'b0, 37'h1000, 64'h0, 1'b1, 64'h0);
    cycle();
    for (lat = 1; lat <= 10; lat++) begin
      @(posedge clk);
      #1;
      if (resp_vld[0]) break;
    end
    chk("miss_latency", 64'(lat), 64'd2);
    set_req(1, 1'b1, 37'h1000, 64'hDEAD, 1'b1, 64'h0);
    cycle();
    idle(2);
    set_req(1, 1'b0, 37'h80, 64'h0, 1'b0, 64'hBAD0);
    cycle();
    idle(3);

    // Backpressure on port 2 for 5 cycles while port 3 streams
    resp_rdy[2] = 1'b0;
    n2 = 0;
    n3 = 0;
    for (int it = 0; it < 40; it++) begin
      if (it == 5) resp_rdy[2] = 1'b1;
      if (!req_vld[2] && n2 < 6) begin
        if (n2 % 2 == 0) set_req(2, 1'b0, 37'h45, 64'h0, 1'b0, 64'hA5A5);
        else             set_req(2, 1'b0, 37'h80, 64'h0, 1'b0, 64'hBAD0);
        n2++;
      end
      if (!req_vld[3] && n3 < 6) begin
        set_req(3, 1'b0, 37'h1C5, 64'h0, 1'b0, 64'hA5A5);
        n3++;
      end
      cycle();
      if (it < 6) chk("p3_accept_full_rate", 64'(acc[3]), 64'h1);
      if (it >= 2 && it < 5) chk("p2_req_rdy_held", 64'(req_rdy[2]), 64'h0);
      if (n2 == 6 && n3 == 6 && !req_vld[2] && !req_vld[3]) break;
    end
    idle(6);

    // Write collision on physical line 0x10: port 3 must win
    set_req(0, 1'b1, 37'h90, 64'h1111, 1'b0, 64'h0);
    set_req(3, 1'b1, 37'h90, 64'h3333, 1'b0, 64'h0);
    cycle();
    idle(1);
    set_req(1, 1'b0, 37'h90, 64'h0, 1'b0, 64'h3333);
    cycle();
    idle(3);

    // Flush with simultaneous fill: everything misses afterwards
    fill(1, 5, 1, 1'b1);
    set_req(0, 1'b0, 37'h140, 64'h0, 1'b1, 64'h0);
    set_req(1, 1'b0, 37'h45, 64'h0, 1'b1, 64'h0);
    cycle();
    idle(3);

    // Fill while a lookup sits in T: that lookup misses, the next one hits
    set_req(0, 1'b0, 37'h140, 64'h0, 1'b1, 64'h0);
    cycle();
    set_req(1, 1'b1, 37'h140, 64'h5555, 1'b0, 64'h0);
    fill(1, 5, 1, 1'b0);
    idle(1);
    set_req(2, 1'b0, 37'h140, 64'h0, 1'b0, 64'h5555);
    cycle();
    idle(3);

    // Reset with requests in flight
    fill(0, 1, 3, 1'b0);
    fill(2, 2, 0, 1'b0);
    set_req(3, 1'b0, 37'h45, 64'h0, 1'b0, 64'hA5A5);
    cycle();
    set_req(0, 1'b1, 37'h45, 64'hBEEF, 1'b0, 64'h0);
    cycle();
    set_req(1, 1'b1, 37'h80, 64'hF00D, 1'b0, 64'h0);
    set_req(2, 1'b1, 37'h90, 64'h7777, 1'b0, 64'h0);
    cycle();
    chk("pre_reset_resp_vld3", 64'(resp_vld[3]), 64'h1);
    #1 rst = 1'b0;
    #1;
    chk("midrst_resp_vld", 64'(resp_vld), 64'h0);
    chk("midrst_resp_fault", 64'(resp_fault), 64'h0);
    chk("midrst_resp_rdata", 64'(|resp_rdata), 64'h0);
    req_vld = '0;
    for (int p = 0; p < NPORT; p++) exp_q[p].delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    set_req(0, 1'b0, 37'h45, 64'h0, 1'b1, 64'h0);
    set_req(1, 1'b0, 37'h80, 64'h0, 1'b1, 64'h0);
    cycle();
    idle(3);
    fill(0, 1, 3, 1'b0);
    fill(2, 2, 0, 1'b0);
    set_req(0, 1'b0, 37'h45, 64'h0, 1'b0, 64'hA5A5);
    set_req(1, 1'b0, 37'h80, 64'h0, 1'b0, 64'hBAD0);
    set_req(2, 1'b0, 37'h90, 64'h0, 1'b0, 64'h3333);
    cycle();
    idle(5);

    for (int p = 0; p < NPORT; p++) begin
      chk($sformatf("scoreboard_drained_p%0d", p), 64'(exp_q[p].size()), 64'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memblk_xlat.md
Name: memblk_xlat

Overview:
- Parametrised successor to the fixed 36-port memory block.
- Multi-port line memory with an integrated, shared, fully associative translation table (TLB).
- Each port presents a virtual line address; the block translates it, then performs the read or write on the physical array.
- Adds per-port valid/ready handshakes with response backpressure, translation-fault reporting, and explicit TLB fill/flush, replacing the global stall and hard-wired widths.

Parameters:
- NPORT, 4, number of independent request/response ports
- DW, 64, data bits per line
- VAW, 37, virtual line-address width
- LAW, 10, physical line-address width; array depth is 2**LAW lines
- POFF, 6, page-offset bits (VPN = VAW-POFF bits, PPN = LAW-POFF bits)
- NTLB, 8, TLB entries

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_vld  in  NPORT  request valid per port
- req_rdy  out  NPORT  request ready per port
- req_we  in  NPORT  1 = write, 0 = read
- req_vaddr  in  NPORT*VAW  virtual line address
- req_wdata  in  NPORT*DW  write data
- resp_vld  out  NPORT  response valid
- resp_rdy  in  NPORT  response accepted
- resp_rdata  out  NPORT*DW  read data; 0 for writes and faults
- resp_fault  out  NPORT  translation miss
- fill_vld  in  1  TLB entry write strobe
- fill_idx  in  clog2(NTLB)  entry index
- fill_vpn  in  VAW-POFF  virtual page number
- fill_ppn  in  LAW-POFF  physical page number
- fill_v  in  1  entry valid bit
- flush  in  1  invalidate all TLB entries

Behaviour:
- Reset (rst low, async):
  - All TLB valid bits = 0; all pipeline valid bits = 0.
  - resp_vld = 0, resp_fault = 0, resp_rdata = 0; req_rdy = 1 once rst is high.
  - Array contents are not reset.
  - Reset mid-operation discards in-flight requests; their writes are not committed.
- Per-port pipeline:
  - Accept when req_vld & req_rdy at edge E; request enters stage T.
  - At E+1: TLB lookup result is registered into stage M.
  - At E+2: the array is accessed and the response registered; resp_vld is high after E+2.
  - Latency: 2 cycles, throughput: 1 request/cycle/port.
- Backpressure:
  - req_rdy[p] = !(resp_vld[p] & !resp_rdy[p]).
  - While held, stages T, M and the response register of port p all freeze.
  - A frozen M-stage write does not commit until it advances.
  - Ports are fully independent; one port holding never stalls another.
- Translation (stage T):
  - Hit = entry valid & entry vpn == vaddr[VAW-1:POFF].
  - Physical address = {ppn, vaddr[POFF-1:0]}.
  - Multiple hits: lowest entry index wins.
  - Miss: resp_fault = 1, resp_rdata = 0, write suppressed.
- TLB update:
  - fill_vld at edge E updates the entry at E; lookups in T during that cycle see the old contents.
  - flush at edge E clears all valid bits.
  - flush and fill_vld in the same cycle: flush wins, so the fill is discarded.
- Array access (stage M):
  - Reads sample the array before same-cycle writes commit, so they return old data.
  - A write at edge E is visible to any read in M at edge E+1 or later.
  - Same-cycle writes from several ports to the same physical line: highest port index wins. All writing ports receive resp_vld with fault = 0.
- Width rules: vaddr bits above VAW are not present; the PPN concatenation is exactly LAW bits; no truncation is permitted.

Decomposition:
- Package memblk_pkg:
  - Default parameter constants.
  - tlb_entry_t {v, vpn, ppn}.
  - req_t {we, vaddr, wdata}.
  - resp_t {fault, rdata}.
  - Function clog2.
- Sub-module memblk_tlb:
  - NTLB-entry storage plus fill/flush logic.
  - NPORT combinational lookup ports returning {hit, ppn}.
  - Instantiated once.
- The top level holds per-port pipelines and the array.

Test Plan:
- TLB mapping: fill idx 0 with vpn 0x1, ppn 0x3, v 1. Port 0 writes vaddr 0x45 with data 0xA5A5. Port 1 reads vaddr 0x45 two cycles later.
  -> Both responses have fault 0; the read returns 0xA5A5; physical line 0xC5 is written.
- Miss: read vaddr 0x1000 with no matching entry -> resp_vld 2 cycles after accept, fault 1, rdata 0. A write to the same vaddr leaves the array unchanged.
- Backpressure: hold resp_rdy[2] = 0 for 5 cycles with back-to-back requests on port 2.
  -> req_rdy[2] = 0 after the first response; no response is lost or duplicated; port 3 continues at full rate.
- Write collision: ports 0 and 3 write physical line 0x10 in the same cycle with 0x1111 and 0x3333 -> a later read returns 0x3333.
- Flush and fill:
  - flush asserted together with fill_vld for idx 1 -> the next lookup of that vpn faults.
  - Fill in the cycle a lookup is in T -> that lookup faults; the following lookup hits.
- Reset: assert rst low while 3 requests are in flight -> resp_vld = 0 immediately; pending writes are absent after release; all lookups fault until refilled.
